// File: rtl/uart_text_bridge.sv
// rtl/uart_text_bridge.sv - UART byte FIFO replayed as timed key strobes for the text screen generator
// Optional feature macro: UART_TEXT_CTRL_MAP_EN (maps BS/DEL to left, CR/LF to down)

module uart_text_bridge #(
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 2_000_000,
    parameter int GAP_CYCLES  = 2_000_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [6:0]               char_out,
    output logic                     set,
    output logic                     left,
    output logic                     down,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     busy
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic [7:0]      head;
    logic            is_print;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    // A pop frees a slot in the same cycle, so a write while full is still taken then
    assign pop      = (state == IDLE) && !empty;
    assign push     = rx_valid && (!full || pop);
    assign head     = mem[rd_ptr];
    assign is_print = (head >= 8'h20) && (head <= 8'h7E);

    assign fifo_count = count;
    assign busy       = (state != IDLE) || !empty;

`ifdef UART_TEXT_CTRL_MAP_EN
    logic left_q;
    logic down_q;
    logic is_left;
    logic is_down;

    assign is_left = (head == 8'h08) || (head == 8'h7F);
    assign is_down = (head == 8'h0D) || (head == 8'h0A);
    assign left    = left_q;
    assign down    = down_q;
`else
    assign left = 1'b0;
    assign down = 1'b0;
`endif

    // Byte storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky loss flag: a byte arrived with no room and no pop to make room
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (rx_valid && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // Replay FSM: pop and classify in IDLE, hold one strobe, then enforce a quiet gap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            char_out <= '0;
            set      <= 1'b0;
`ifdef UART_TEXT_CTRL_MAP_EN
            left_q   <= 1'b0;
            down_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (is_print) begin
                            char_out <= head[6:0];
                            set      <= 1'b1;
                            cnt      <= CW'(HOLD_CYCLES - 1);
                            state    <= HOLD;
                        end
`ifdef UART_TEXT_CTRL_MAP_EN
                        else if (is_left) begin
                            left_q <= 1'b1;
                            cnt    <= CW'(HOLD_CYCLES - 1);
                            state  <= HOLD;
                        end else if (is_down) begin
                            down_q <= 1'b1;
                            cnt    <= CW'(HOLD_CYCLES - 1);
                            state  <= HOLD;
                        end
`endif
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        set   <= 1'b0;
`ifdef UART_TEXT_CTRL_MAP_EN
                        left_q <= 1'b0;
                        down_q <= 1'b0;
`endif
                        cnt   <= CW'(GAP_CYCLES - 1);
                        state <= GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_text_bridge.sv
// tb/tb_uart_text_bridge.sv - self-checking bench for uart_text_bridge

module tb_uart_text_bridge;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int GAP   = 2;

`ifdef UART_TEXT_CTRL_MAP_EN
    localparam logic [2:0] SL = 3'b010;
    localparam logic [2:0] SD = 3'b001;
`else
    localparam logic [2:0] SL = 3'b000;
    localparam logic [2:0] SD = 3'b000;
`endif
    localparam logic [2:0] SS = 3'b100;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [6:0] char_out;
    logic       set;
    logic       left;
    logic       down;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       busy;
    logic [2:0] strobes;

    assign strobes = {set, left, down};

    uart_text_bridge #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .char_out   (char_out),
        .set        (set),
        .left       (left),
        .down       (down),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct packed {
        logic [2:0] s;
        logic [6:0] c;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] strobe;
        logic [6:0] chr;
    } vec_t;

    exp_t       exp_q[$];
    int         rises[$];
    logic [6:0] last_char = 7'h00;
    int         last_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: pops the expected strobe on each rising edge and checks hold width
    logic [2:0] prev_s = 3'b000;
    int         hi_len = 0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_s = 3'b000;
            hi_len = 0;
        end else begin
            if (strobes != 3'b000) begin
                chk("strobe_onehot", $countones(strobes), 1);
            end
            if (strobes != 3'b000 && prev_s == 3'b000) begin
                rises.push_back(cyc);
                hi_len = 1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {29'd0, strobes}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("strobe_kind", {29'd0, strobes}, {29'd0, e.s});
                    chk("strobe_char", {25'd0, char_out}, {25'd0, e.c});
                end
            end else if (strobes != 3'b000) begin
                hi_len++;
            end else if (prev_s != 3'b000) begin
                chk("hold_width", hi_len, HOLD);
                hi_len = 0;
            end
            prev_s = strobes;
        end
    end

    task automatic drive(input logic [7:0] b, input logic [2:0] s);
        rx_data  = b;
        rx_valid = 1'b1;
        if (s == SS) last_char = b[6:0];
        if (s != 3'b000) exp_q.push_back({s, last_char});
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        last_w   = cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || strobes != 3'b000) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL idle_timeout: busy %0b still high after %0d cycles", busy, n);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t tv[11];

    initial begin
        int w;
        tv[0]  = '{8'h41, SS,     7'h41};
        tv[1]  = '{8'h7E, SS,     7'h7E};
        tv[2]  = '{8'h20, SS,     7'h20};
        tv[3]  = '{8'h1F, 3'b000, 7'h20};
        tv[4]  = '{8'h7F, SL,     7'h20};
        tv[5]  = '{8'h08, SL,     7'h20};
        tv[6]  = '{8'h0D, SD,     7'h20};
        tv[7]  = '{8'h0A, SD,     7'h20};
        tv[8]  = '{8'h80, 3'b000, 7'h20};
        tv[9]  = '{8'hC1, 3'b000, 7'h20};
        tv[10] = '{8'h5A, SS,     7'h5A};

        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        #3;
        chk("reset_char_out", char_out, 0);
        chk("reset_strobes", strobes, 0);
        chk("reset_fifo_count", fifo_count, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_busy", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single-byte vectors: latency, hold/gap timing, classification
        for (int i = 0; i < 11; i++) begin
            wait_idle();
            rises.delete();
            drive(tv[i].data, tv[i].strobe);
            w = last_w;
            chk("fifo_count_after_write", fifo_count, 1);
            @(posedge clk);
            #1;
            chk("strobe_at_pop", strobes, tv[i].strobe);
            chk("char_at_pop", char_out, tv[i].chr);
            chk("fifo_count_after_pop", fifo_count, 0);
            chk("busy_at_pop", busy, tv[i].strobe != 3'b000);
            if (tv[i].strobe != 3'b000) begin
                repeat (HOLD - 1) @(posedge clk);
                #1;
                chk("strobe_end_of_hold", strobes, tv[i].strobe);
                @(posedge clk);
                #1;
                chk("strobe_after_hold", strobes, 0);
                chk("busy_in_gap", busy, 1);
                repeat (GAP - 1) @(posedge clk);
                #1;
                chk("busy_end_of_gap", busy, 1);
                @(posedge clk);
                #1;
                chk("busy_after_gap", busy, 0);
            end
            wait_idle();
            chk("rise_count", rises.size(), tv[i].strobe != 3'b000);
            if (tv[i].strobe != 3'b000 && rises.size() > 0) chk("rise_cycle", rises[0], w + 1);
        end

        // Burst of three printable bytes on consecutive cycles
        wait_idle();
        rises.delete();
        drive(8'h48, SS);
        w = last_w;
        chk("burst_count_1", fifo_count, 1);
        drive(8'h49, SS);
        chk("burst_count_2", fifo_count, 1);
        drive(8'h21, SS);
        chk("burst_count_3", fifo_count, 2);
        wait_idle();
        chk("burst_rises", rises.size(), 3);
        if (rises.size() == 3) begin
            chk("burst_first", rises[0], w + 1);
            chk("burst_spacing_1", rises[1] - rises[0], HOLD + GAP + 1);
            chk("burst_spacing_2", rises[2] - rises[1], HOLD + GAP + 1);
        end

        // Unmapped byte followed by a printable one: one extra cycle of latency
        wait_idle();
        rises.delete();
        drive(8'h01, 3'b000);
        w = last_w;
        drive(8'h5A, SS);
        wait_idle();
        chk("skip_rises", rises.size(), 1);
        if (rises.size() == 1) chk("skip_rise_cycle", rises[0], w + 2);

        // Control pair: left then down, char_out untouched
        wait_idle();
        rises.delete();
        drive(8'h08, SL);
        w = last_w;
        drive(8'h0D, SD);
        wait_idle();
        chk("ctrl_char_kept", char_out, last_char);
`ifdef UART_TEXT_CTRL_MAP_EN
        chk("ctrl_rises", rises.size(), 2);
        if (rises.size() == 2) begin
            chk("ctrl_left_rise", rises[0], w + 1);
            chk("ctrl_down_rise", rises[1], w + 1 + HOLD + GAP + 1);
        end
`else
        chk("ctrl_rises", rises.size(), 0);
`endif
        chk("overflow_before_fill", overflow, 0);

        // Overflow: 6 back-to-back bytes, then a write coinciding with a pop while full
        wait_idle();
        rises.delete();
        for (int k = 0; k < 5; k++) begin
            drive(8'h30 + 8'(k), SS);
        end
        chk("fill_count", fifo_count, 4);
        chk("fill_no_overflow", overflow, 0);
        drive(8'h35, 3'b000);
        chk("overflow_count", fifo_count, 4);
        chk("overflow_set", overflow, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("full_before_pop", fifo_count, 4);
        drive(8'h36, SS);
        chk("full_write_with_pop", fifo_count, 4);
        wait_idle();
        chk("overflow_rises", rises.size(), 6);
        chk("overflow_sticky", overflow, 1);
        chk("overflow_queue_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a hold
        wait_idle();
        drive(8'h55, SS);
        drive(8'h56, SS);
        @(posedge clk);
        #1;
        chk("pre_reset_set", set, 1);
        chk("pre_reset_count", fifo_count, 1);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("async_reset_set", set, 0);
        chk("async_reset_char", char_out, 0);
        chk("async_reset_count", fifo_count, 0);
        chk("async_reset_overflow", overflow, 0);
        chk("async_reset_busy", busy, 0);
        last_char = 7'h00;
        rises.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_no_strobe", rises.size(), 0);
        chk("post_reset_count", fifo_count, 0);
        drive(8'h42, SS);
        wait_idle();
        chk("post_reset_rises", rises.size(), 1);
        chk("post_reset_char", char_out, 7'h42);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
